// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the program counter, fetches one word at a
// time from instruction memory (never more than one request in flight) and
// parks the returned instruction in a single-entry buffer for decode.
// Handles decode stalls, branch/jump redirects (discarding stale responses)
// and a sticky halt.
//
// Handshakes:
//   imem_req/imem_gnt : a request transfers on a rising edge where both are 1.
//     imem_addr is only meaningful while imem_req=1. Once granted, imem_req
//     stays low until the matching imem_rvalid has been seen.
//   imem_rvalid       : one-cycle response strobe; there is no back-pressure,
//     so the data is taken (or deliberately dropped) at that edge.
//   if_valid/id_ready : the buffer transfers to decode on an edge where both
//     are 1. if_instr/if_pc hold steady while if_valid=1 and id_ready=0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   imem_req, imem_addr   request strobe and word address (equals pc)
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     response strobe and instruction word
//   if_valid/instr/pc     output buffer towards decode
//   id_ready              decode consumes the buffer at this edge
//   redirect_valid/pc     one-cycle redirect from branch/JAL/JALR resolution
//   halt_req, halted      sticky halt request, fetch permanently stopped
//   fsm_state             current FSM state, for observation only
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;   // address of the request currently in flight
  logic        kill;     // next response belongs to a squashed fetch
  logic        halting;  // halt seen, stop after the in-flight fetch

  logic [31:0] redirect_target;
  logic        accepted;

  // Instructions are word aligned, so the low two bits of a target are ignored.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A new request may go out only if the buffer is empty or being emptied at
  // this same edge, which is what keeps the single buffer from overflowing.
  assign imem_req  = reset_n && (state == S_REQ) && !halting && (!if_valid || id_ready);
  assign imem_addr = pc;
  assign accepted  = imem_req && imem_gnt;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      kill     <= 1'b0;
      halting  <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
      halted   <= 1'b0;
    end else begin
      if (halt_req) halting <= 1'b1;

      // Decode drain; a response loading the buffer at this edge overrides it.
      if (if_valid && id_ready) if_valid <= 1'b0;

      case (state)
        S_REQ: begin
          if (accepted) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end else if (halting) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end
          // Redirect wins over pc+4. A request accepted at this very edge
          // fetched the old path, so its response must be thrown away.
          if (redirect_valid) begin
            pc       <= redirect_target;
            if_valid <= 1'b0;
            if (accepted) kill <= 1'b1;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc       <= redirect_target;
            if_valid <= 1'b0;
            if (imem_rvalid) begin
              // The in-flight response is stale; consume and drop it now.
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill <= 1'b0;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= req_pc;
              if_valid <= 1'b1;
            end
            if (halting) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end

        S_HALTED: begin
          // Terminal until reset; only the buffer drain above is active.
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the instruction decoder and main controller. Maintains the program counter and issues word requests to instruction memory over a request/grant/response handshake, with at most one request outstanding. Holds the returned instruction in a single-entry output buffer for decode, and handles stalls, branch/jump redirects (including discarding stale responses) and halt.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid; forced 0 while reset_n=0.
- imem_addr  out  32  request word address; equals the internal pc.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction word.
- if_valid  out  1  output buffer holds an instruction.
- if_instr  out  32  buffered instruction; bits [6:0] feed the controller's Opcode input.
- if_pc  out  32  address of if_instr.
- id_ready  in  1  decode consumes the buffer at this edge if if_valid=1.
- redirect_valid  in  1  one-cycle redirect from branch/JAL/JALR resolution.
- redirect_pc  in  32  redirect target; bits [1:0] cleared internally.
- halt_req  in  1  stop fetching; sticky once seen.
- halted  out  1  fetch permanently stopped until reset.

## Operation
- States: REQ, WAIT, HALTED. Flags: kill (discard next response), halting.
- Reset values: state=REQ, pc=RESET_PC, kill=0, halting=0, if_valid=0, if_instr=0, if_pc=0, halted=0.
- REQ: imem_req = !halting && (!if_valid || id_ready). On imem_req && imem_gnt: req_pc<=pc, pc<=pc+4 (mod 2^32), go to WAIT. If halting and no request is issued, go to HALTED.
- WAIT: imem_req=0. On imem_rvalid: if kill, drop the data and clear kill; else if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1. Then go to REQ, or to HALTED if halting.
- Buffer drain: if_valid && id_ready clears if_valid, unless a response loads the buffer in the same edge.
- Redirect (state REQ or WAIT), applied at that edge:
  - pc<={redirect_pc[31:2],2'b00}; if_valid<=0.
  - In WAIT without rvalid: kill<=1.
  - In WAIT with rvalid: the response is discarded and state goes to REQ.
  - In REQ with an accepted request: go to WAIT with kill<=1.
  - Redirect overrides pc+4.
- Halt: halt_req sets halting. The outstanding request completes and is delivered unless killed. Then HALTED: halted=1, imem_req=0. The buffer can still be drained. Redirects are ignored in HALTED.
- imem_rvalid in REQ or HALTED (no outstanding request) is ignored.
- Reset mid-operation: all state is cleared immediately; a stray response after reset is ignored.

## Timing
- First request in the first cycle after reset_n rises, at address RESET_PC.
- Response may arrive 1 or more cycles after grant; it is captured at that edge, and if_valid rises the following cycle.
- With gnt=1, rvalid one cycle after grant, and id_ready=1: one instruction every 2 cycles; requests at cycles 0, 2, 4, ...
- Stall: while if_valid=1 and id_ready=0, if_instr and if_pc are stable and no request is issued.
- Redirect-to-request latency: the new address is on imem_addr the cycle after redirect if state=REQ, or the cycle after the pending response drains.

## Test plan
- Reset, gnt=1, rvalid one cycle after grant, id_ready=1, rdata=addr+0x100 -> imem_addr 0x0, 0x4, 0x8 at cycles 0, 2, 4; if_valid at cycle 2 with if_pc=0x0, if_instr=0x100.
- Buffer holds 0x00500093 at if_pc=0x4, id_ready=0 for 5 cycles -> imem_req=0 and outputs stable; id_ready=1 -> request at 0x8 in that same cycle.
- Redirect to 0x107 during WAIT (pending fetch of 0x8) -> response discarded, if_valid=0, next imem_addr=0x104, delivered if_pc=0x104.
- Redirect to 0x200 in the same cycle as rvalid -> data dropped, next request at 0x200, no delivery of the old pc.
- halt_req during WAIT for 0xC -> 0xC delivered, no further imem_req, halted=1 the cycle after the response; redirect to 0x40 ignored.
- reset_n low during WAIT, stray rvalid after release -> outputs at reset values, rvalid ignored, first request at RESET_PC.
